// File: rtl/ad5681r_dac_ctrl.sv
// AD5681R 12-bit DAC sequencer: power-up RSTn sequence, then one 24-bit SPI frame
// or one hardware LDACn pulse per accepted command. Every pin output is registered.
module ad5681r_dac_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int RST_CYCLES  = 50,
  parameter int RST_WAIT    = 50,
  parameter int LDAC_CYCLES = 2,
  parameter int SYNC_HIGH   = 4
) (
  input  logic        SYS_CLK,
  input  logic        RESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [11:0] cmd_data,
  output logic        busy,
  output logic        done,
  output logic        init_done,
  output logic        AD5681R_SYNCn,
  output logic        AD5681R_SCL,
  output logic        AD5681R_SDA,
  output logic        AD5681R_LDACn,
  output logic        AD5681R_RSTn
);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_RST_WAIT,
    S_IDLE,
    S_SHIFT,
    S_LDAC,
    S_GAP
  } state_t;

  localparam logic [15:0] DIV_M1     = 16'(CLK_DIV - 1);
  localparam logic [15:0] RC_M1      = 16'(RST_CYCLES - 1);
  localparam logic [15:0] RW_M1      = 16'(RST_WAIT - 1);
  localparam logic [15:0] LC_M1      = 16'(LDAC_CYCLES - 1);
  localparam logic [15:0] SH_LAST    = 16'(SYNC_HIGH);
  localparam logic [15:0] SH_M1      = 16'(SYNC_HIGH - 1);
  localparam logic [5:0]  LAST_PHASE = 6'd47;

  function automatic logic [23:0] build_frame(input logic [1:0] op, input logic [11:0] data);
    logic [3:0] nibble;
    case (op)
      2'd0:    nibble = 4'h3;
      2'd1:    nibble = 4'h1;
      default: nibble = 4'h2;
    endcase
    return {nibble, (op == 2'd2) ? 12'h000 : data, 8'h00};
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;       // generic dwell counter; SCL half-period counter in SHIFT
  logic [5:0]  phase_q, phase_d;   // SCL half-period index 0..47 within a frame
  logic [22:0] shreg_q, shreg_d;   // frame bits still to be presented on SDA
  logic [23:0] frame;
  logic        sync_d, scl_d, sda_d, ldac_d, rstn_d;
  logic        ready_d, busy_d, done_d, init_d;

  assign frame = build_frame(cmd_op, cmd_data);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    sync_d  = AD5681R_SYNCn;
    scl_d   = AD5681R_SCL;
    sda_d   = AD5681R_SDA;
    ldac_d  = AD5681R_LDACn;
    rstn_d  = AD5681R_RSTn;
    ready_d = cmd_ready;
    busy_d  = busy;
    done_d  = 1'b0;
    init_d  = init_done;

    case (state_q)
      S_RST_HOLD: begin
        if (cnt_q == RC_M1) begin
          state_d = S_RST_WAIT;
          cnt_d   = '0;
          rstn_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RST_WAIT: begin
        if (cnt_q == RW_M1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          init_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          if (cmd_op == 2'd3) begin
            state_d = S_LDAC;
            ldac_d  = 1'b0;
          end else begin
            state_d = S_SHIFT;
            phase_d = '0;
            sync_d  = 1'b0;
            scl_d   = 1'b1;
            sda_d   = frame[23];
            shreg_d = frame[22:0];
          end
        end
      end

      S_SHIFT: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          phase_d = phase_q + 6'd1;
          if (phase_q == LAST_PHASE) begin
            state_d = S_GAP;
            sync_d  = 1'b1;
            scl_d   = 1'b1;
            sda_d   = 1'b0;
          end else if (!phase_q[0]) begin
            scl_d = 1'b0;  // falling edge: DAC samples, SDA must hold
          end else begin
            scl_d   = 1'b1;
            sda_d   = shreg_q[22];
            shreg_d = {shreg_q[21:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_LDAC: begin
        if (cnt_q == LC_M1) begin
          state_d = S_GAP;
          cnt_d   = '0;
          ldac_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // GAP spans SYNC_HIGH+1 cycles so done lands op_length+SYNC_HIGH+1 cycles after acceptance.
      S_GAP: begin
        if (cnt_q == SH_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          done_d = (cnt_q == SH_M1);
        end
      end

      default: state_d = S_RST_HOLD;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= S_RST_HOLD;
      cnt_q         <= '0;
      phase_q       <= '0;
      shreg_q       <= '0;
      AD5681R_SYNCn <= 1'b1;
      AD5681R_SCL   <= 1'b1;
      AD5681R_SDA   <= 1'b0;
      AD5681R_LDACn <= 1'b1;
      AD5681R_RSTn  <= 1'b0;
      cmd_ready     <= 1'b0;
      busy          <= 1'b1;
      done          <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      shreg_q       <= shreg_d;
      AD5681R_SYNCn <= sync_d;
      AD5681R_SCL   <= scl_d;
      AD5681R_SDA   <= sda_d;
      AD5681R_LDACn <= ldac_d;
      AD5681R_RSTn  <= rstn_d;
      cmd_ready     <= ready_d;
      busy          <= busy_d;
      done          <= done_d;
      init_done     <= init_d;
    end
  end

endmodule
